// File: rtl/data_memory_param_if.sv
// Request/response bundle between the MEM stage and data_memory_param.
// The master drives read/write requests; the slave returns data, status and busy.
interface data_memory_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic                  read_enable;
   logic [ADDR_W-1:0]     read_addr;
   logic [DATA_W-1:0]     read_data;
   logic                  read_valid;
   logic                  write_enable;
   logic [ADDR_W-1:0]     write_addr;
   logic [DATA_W-1:0]     write_data;
   logic [DATA_W/8-1:0]   write_strb;
   logic                  busy;
   logic                  addr_error;

   modport master (
      output read_enable, read_addr, write_enable, write_addr, write_data, write_strb,
      input  read_data, read_valid, busy, addr_error
   );

   modport slave (
      input  read_enable, read_addr, write_enable, write_addr, write_data, write_strb,
      output read_data, read_valid, busy, addr_error
   );
endinterface

// File: rtl/data_memory_param.sv
// Parametrised single-clock data memory: byte-strobed writes, registered reads with
// write-first forwarding, range checking and an optional post-reset zeroing sweep.
module data_memory_param #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = 2048,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic               clk,
   input  logic               reset,
   data_memory_param_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = DATA_W / 8;
   // One extra bit so DEPTH == 2^ADDR_W is representable in the range compare.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic { S_CLEAR, S_READY } state_t;

   state_t              state;
   logic [IDX_W-1:0]    clr_ptr;
   logic                busy_q;
   logic [DATA_W-1:0]   rd_data_p1;
   logic                vld_p1;
   logic                err_p1;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                rd_in_range;
   logic                wr_in_range;
   logic [IDX_W-1:0]    ridx;
   logic [IDX_W-1:0]    widx;
   logic                ready;
   logic                rd_ok;
   logic                wr_ok;
   logic                clr_we;
   logic [DATA_W-1:0]   wr_word;
   logic [DATA_W-1:0]   rd_word;

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [NB-1:0]     strb
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < NB; i++) begin
         if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

   assign rd_in_range = ({1'b0, bus.read_addr} < DEPTH_X);
   assign wr_in_range = ({1'b0, bus.write_addr} < DEPTH_X);
   assign ridx        = bus.read_addr[IDX_W-1:0];
   assign widx        = bus.write_addr[IDX_W-1:0];
   assign ready       = (state == S_READY) && !reset;
   assign rd_ok       = ready && bus.read_enable && rd_in_range;
   assign wr_ok       = ready && bus.write_enable && wr_in_range;
   assign clr_we      = (state == S_CLEAR) && !reset;
   assign wr_word     = merge_bytes(mem[widx], bus.write_data, bus.write_strb);

   // Same-address collision forwards the merged post-write word.
   always_comb begin
      rd_word = mem[ridx];
      if (wr_ok && (widx == ridx)) rd_word = wr_word;
   end

   always_ff @(posedge clk) begin
      if (clr_we)     mem[clr_ptr] <= '0;
      else if (wr_ok) mem[widx]    <= wr_word;
   end

   // Stage p0 -> p1: request sampled, registered response and control.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_p1 <= '0;
         vld_p1     <= 1'b0;
         err_p1     <= 1'b0;
         clr_ptr    <= '0;
         state      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         busy_q     <= (CLEAR_ON_RESET != 0);
      end else begin
         case (state)
            S_CLEAR: begin
               vld_p1  <= 1'b0;
               err_p1  <= 1'b0;
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == LAST_IDX) begin
                  state  <= S_READY;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               vld_p1 <= bus.read_enable;
               err_p1 <= (bus.read_enable && !rd_in_range) ||
                         (bus.write_enable && !wr_in_range);
               if (bus.read_enable) rd_data_p1 <= rd_ok ? rd_word : '0;
            end
         endcase
      end
   end

   assign bus.read_data  = rd_data_p1;
   assign bus.read_valid = vld_p1;
   assign bus.addr_error = err_p1;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param (DATA_W=16, ADDR_W=16, DEPTH=16, clear on reset).
module tb_data_memory_param;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 16;

   logic clk;
   logic reset;
   int   vectors;
   int   errors;
   logic [15:0] model [DEPTH];

   data_memory_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

   data_memory_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bif.read_enable  = 1'b0;
      bif.write_enable = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
      bif.write_enable = 1'b1;
      bif.write_addr   = a;
      bif.write_data   = d;
      bif.write_strb   = s;
      step();
      bif.write_enable = 1'b0;
      if (a < DEPTH) begin
         if (s[0]) model[a[3:0]][7:0]  = d[7:0];
         if (s[1]) model[a[3:0]][15:8] = d[15:8];
      end
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
      bif.read_enable = 1'b1;
      bif.read_addr   = a;
      step();
      bif.read_enable = 1'b0;
      chk({tag, "_vld"}, 32'(bif.read_valid), 32'd1);
      chk(tag, 32'(bif.read_data), 32'(exp));
   endtask

   initial begin
      int n;
      vectors = 0;
      errors  = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
      bif.read_enable  = 1'b0;
      bif.read_addr    = '0;
      bif.write_enable = 1'b0;
      bif.write_addr   = '0;
      bif.write_data   = '0;
      bif.write_strb   = '0;

      // 1. reset and clear sweep
      reset = 1'b1;
      step();
      step();
      chk("rst_busy", 32'(bif.busy), 32'd1);
      chk("rst_vld", 32'(bif.read_valid), 32'd0);
      chk("rst_data", 32'(bif.read_data), 32'd0);
      chk("rst_err", 32'(bif.addr_error), 32'd0);
      reset = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (bif.busy && n < 40);
      chk("busy_len", 32'(n), 32'd16);
      for (int a = 0; a < DEPTH; a++) rd("clr_rd", 16'(a), 16'h0000);

      // 2. basic write/read and hold
      wr(16'h0002, 16'h0001, 2'b11);
      rd("basic_rd", 16'h0002, 16'h0001);
      step();
      chk("hold_vld", 32'(bif.read_valid), 32'd0);
      chk("hold_data", 32'(bif.read_data), 32'h0001);

      // 3. byte strobes
      wr(16'd5, 16'hABCD, 2'b11);
      wr(16'd5, 16'h1234, 2'b01);
      rd("strb_rd", 16'd5, 16'hAB34);
      wr(16'd5, 16'hFFFF, 2'b00);
      chk("strb0_err", 32'(bif.addr_error), 32'd0);
      rd("strb0_rd", 16'd5, 16'hAB34);

      // 4. collision
      wr(16'd7, 16'h00FF, 2'b11);
      bif.write_enable = 1'b1;
      bif.write_addr   = 16'd7;
      bif.write_data   = 16'h5500;
      bif.write_strb   = 2'b10;
      bif.read_enable  = 1'b1;
      bif.read_addr    = 16'd7;
      step();
      idle();
      model[7] = 16'h55FF;
      chk("coll_vld", 32'(bif.read_valid), 32'd1);
      chk("coll_data", 32'(bif.read_data), 32'h55FF);
      rd("coll_rd2", 16'd7, 16'h55FF);

      // 5. out of range
      wr(16'h0010, 16'hDEAD, 2'b11);
      chk("oorw_err", 32'(bif.addr_error), 32'd1);
      step();
      chk("oorw_err_end", 32'(bif.addr_error), 32'd0);
      for (int a = 0; a < DEPTH; a++) rd("oorw_rd", 16'(a), model[a]);
      rd("oorr", 16'hFFFF, 16'h0000);
      chk("oorr_err", 32'(bif.addr_error), 32'd1);
      bif.write_enable = 1'b1;
      bif.write_addr   = 16'h0010;
      bif.write_data   = 16'hDEAD;
      bif.write_strb   = 2'b11;
      bif.read_enable  = 1'b1;
      bif.read_addr    = 16'h8000;
      step();
      idle();
      chk("both_err", 32'(bif.addr_error), 32'd1);
      chk("both_vld", 32'(bif.read_valid), 32'd1);
      chk("both_data", 32'(bif.read_data), 32'h0000);
      step();
      chk("both_err_end", 32'(bif.addr_error), 32'd0);

      // 6. reset mid-clear
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (9) step();
      chk("mid_busy", 32'(bif.busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      bif.write_enable = 1'b1;
      bif.write_addr   = 16'd3;
      bif.write_data   = 16'h1111;
      bif.write_strb   = 2'b11;
      bif.read_enable  = 1'b1;
      bif.read_addr    = 16'd2;
      n = 0;
      do begin
         step();
         n++;
         chk("busy_vld", 32'(bif.read_valid), 32'd0);
         chk("busy_err", 32'(bif.addr_error), 32'd0);
      end while (bif.busy && n < 40);
      idle();
      chk("mid_busy_len", 32'(n), 32'd16);
      rd("mid_rd3", 16'd3, 16'h0000);
      rd("mid_rd2", 16'd2, 16'h0000);
      rd("mid_rd7", 16'd7, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
